// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave.
package spi_pkg;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the byte-level tx/rx handshake of the SPI slave.
interface spi_slave_if;
  import spi_pkg::*;

  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              SS;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;

  modport slave (
    input  sclk, mosi, SS, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, tx_underrun
  );

  modport master (
    output sclk, mosi, SS, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, tx_underrun
  );
endinterface

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer with a configurable reset value.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave with a one-entry tx buffer, oversampled on clk.
// Define MISO_TRISTATE_EN to float miso when the slave is not selected.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  spi_slave_if.slave  bus
);
  logic sclk_s, mosi_s, ss_s;
  logic sclk_p1, ss_p1;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  state_t            state, state_nxt;
  logic              active, load;
  logic [DATA_W-1:0] tx_shift, rx_shift, tx_buf, rx_data_q;
  logic [2:0]        bit_cnt;
  logic              buf_full, rx_valid_q, underrun_q;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(bus.sclk), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(bus.mosi), .q(mosi_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d(bus.SS), .q(ss_s));

  // Edge detect stage: previous synchronized samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_p1 <= 1'b0;
      ss_p1   <= 1'b1;
    end else begin
      sclk_p1 <= sclk_s;
      ss_p1   <= ss_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_p1;
  assign sclk_fall = ~sclk_s & sclk_p1;
  assign ss_fall   = ~ss_s & ss_p1;
  assign ss_rise   = ss_s & ~ss_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Deselect wins over a coincident sclk edge, so a byte ending together
  // with SS does not trigger a reload.
  always_comb begin
    state_nxt = state;
    active    = (state == SHIFT) && !ss_rise;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) state_nxt = IDLE;
        else if (sclk_fall && bit_cnt == 3'd0) load = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift stage: byte loads, serial shifting and rx capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift   <= '0;
      rx_shift   <= '0;
      tx_buf     <= '0;
      rx_data_q  <= '0;
      bit_cnt    <= 3'd0;
      buf_full   <= 1'b0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;

      if (load) begin
        if (buf_full) begin
          tx_shift <= tx_buf;
          buf_full <= 1'b0;
        end else begin
          tx_shift   <= '0;
          underrun_q <= 1'b1;
        end
      end else if (active && sclk_fall) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end

      // A write can only land while the buffer is empty, so it never
      // collides with a load that drains a full buffer.
      if (bus.tx_valid && !buf_full) begin
        tx_buf   <= bus.tx_data;
        buf_full <= 1'b1;
      end

      if (state == IDLE && ss_fall) begin
        bit_cnt <= 3'd0;
      end else if (active && sclk_rise) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data_q  <= {rx_shift[DATA_W-2:0], mosi_s};
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.tx_ready    = ~buf_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;

`ifdef MISO_TRISTATE_EN
  assign bus.miso = (state == SHIFT) ? tx_shift[DATA_W-1] : 1'bz;
`else
  assign bus.miso = (state == SHIFT) ? tx_shift[DATA_W-1] : 1'b0;
`endif
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for sclk, mosi and SS (legal values 2..3).
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port sclk, input, 1 bit: SPI clock from master, asynchronous to clk.
REQ-005 SHALL have port mosi, input, 1 bit: serial data from master, MSB first.
REQ-006 SHALL have port miso, output, 1 bit: serial data to master, MSB first.
REQ-007 SHALL have port SS, input, 1 bit: slave select, active-low.
REQ-008 SHALL have port tx_data, input, 8 bits: next byte to transmit.
REQ-009 SHALL have port tx_valid, input, 1 bit: tx_data offered.
REQ-010 SHALL have port tx_ready, output, 1 bit: one-entry tx buffer empty.
REQ-011 SHALL have port rx_data, output, 8 bits: last complete received byte.
REQ-012 SHALL have port rx_valid, output, 1 bit: one-clk pulse, rx_data updated.
REQ-013 SHALL have port tx_underrun, output, 1 bit: one-clk pulse, byte started with empty buffer.

Function
REQ-014 SHALL implement SPI mode 0: sample mosi on sclk rising edge, change miso on sclk falling edge.
REQ-015 SHALL pass sclk, mosi and SS through SYNC_STAGES flops and detect sclk edges from the last two synchronized samples.
REQ-016 SHALL use states IDLE (SS high) and SHIFT (SS low).
REQ-017 SHALL move IDLE->SHIFT on synchronized SS falling: bit_cnt=0; shifter loaded from buffer.
REQ-018 SHALL move SHIFT->IDLE on synchronized SS rising, from any bit position.
REQ-019 SHALL drive miso from tx shifter bit 7 while in SHIFT.
REQ-020 SHALL, on each sclk rising in SHIFT: rx_shift={rx_shift[6:0],mosi_sync}; bit_cnt+1 (3-bit, wraps 7->0).
REQ-021 SHALL, on the rising edge where bit_cnt==7: rx_data={rx_shift[6:0],mosi_sync}; rx_valid=1 on the next clk.
REQ-022 SHALL, on each sclk falling in SHIFT: reload from buffer if bit_cnt==0, else shift tx left by 1 with zero fill.
REQ-023 SHALL handle every byte load (REQ-017, REQ-022) as follows: buffer full -> load it and set tx_ready=1; buffer empty -> load 8'h00 and pulse tx_underrun.
REQ-024 SHALL write the buffer on clk when tx_valid && tx_ready.
REQ-025 SHALL give priority to the load when a write and a load occur in the same clk: the buffer becomes empty, and the offered byte is not accepted because tx_ready was 0.
REQ-026 SHALL, on SS rising with bit_cnt!=0: discard the partial byte, generate no rx_valid, and keep the buffer contents.
REQ-027 SHALL overwrite rx_data on a new byte even if the previous byte was unread (no flow control on rx).
REQ-028 SHALL support back-to-back bytes while SS stays low, with no gap cycles required.
REQ-029 SHALL require each sclk high and low phase to be at least SYNC_STAGES+2 clk cycles; the team master provides 50.

Reset
REQ-030 SHALL, while reset is low: state=IDLE, shifters=0, bit_cnt=0, buffer empty, tx_ready=1, rx_data=8'h00, rx_valid=0, tx_underrun=0, miso per REQ-032/033, and clear synchronizers to sclk=0 and SS=1.
REQ-031 SHALL abandon a transfer if reset is asserted mid-transfer, and wait for a fresh SS falling edge after release.

Configuration
REQ-032 With MISO_TRISTATE_EN defined, SHALL drive miso as 1'bz whenever the state is not SHIFT.
REQ-033 Without MISO_TRISTATE_EN, SHALL drive miso as 1'b0 whenever the state is not SHIFT.

Structure
REQ-034 SHALL place the state enum (IDLE, SHIFT) and localparam DATA_W=8 in shared package spi_pkg.
REQ-035 SHALL implement synchronization in one sub-module, spi_sync (parameterized depth, reset value, 1-bit), instantiated three times.

Verification
REQ-036 SHALL test a basic byte: preload 8'hA5, master sends 8'h3C at 50-clk half-period -> rx_data=8'h3C with a single rx_valid pulse; master receives 8'hA5.
REQ-037 SHALL test back-to-back bytes: SS held low, 8'h11 then 8'h22 loaded -> master gets 8'h11, 8'h22; two rx_valid pulses.
REQ-038 SHALL test underrun: no preload, master sends 8'hFF -> one tx_underrun pulse; master receives 8'h00; rx_data=8'hFF.
REQ-039 SHALL test abort: SS released after 3 sclk rising edges -> no rx_valid; rx_data unchanged; the next full transfer is correct.
REQ-040 SHALL test reset mid-transfer: reset low at bit 4 -> all outputs at reset values; the next transfer of 8'h5A is received correctly.
REQ-041 SHALL test both macro builds: with SS high, miso is 1'bz with MISO_TRISTATE_EN and 1'b0 without it.
